// File: rtl/rcpfa_serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice reused over WIDTH/DIGIT cycles.
// Operands in and results out over valid/ready handshakes.
module rcpfa_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("rcpfa_serial_adder: bad WIDTH/DIGIT");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT:0]   w_slice;
  logic [WIDTH-1:0] w_dig;
  logic [WIDTH-1:0] w_acc_nx;
  logic             w_cmsb;
  logic             w_last;

  assign w_slice = {1'b0, r_a[DIGIT-1:0]}
                 + {1'b0, r_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};

  // carry into the slice's top bit, recovered from its sum bit
  assign w_cmsb = w_slice[DIGIT-1]
                ^ r_a[DIGIT-1]
                ^ r_b[DIGIT-1];

  assign w_dig    = WIDTH'(w_slice[DIGIT-1:0]);
  assign w_acc_nx = (r_acc >> DIGIT)
                  | (w_dig << (WIDTH - DIGIT));
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= Sub ? ~B : B;
            r_carry <= Sub ? ~Cin : Cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_acc   <= w_acc_nx;
          r_carry <= w_slice[DIGIT];
          if (w_last) begin
            r_sum   <= w_acc_nx;
            r_cout  <= w_slice[DIGIT];
            r_ovf   <= w_cmsb ^ w_slice[DIGIT];
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Ovf       = r_ovf;

endmodule

// File: tb/tb_rcpfa_serial_adder.sv
// Bench for rcpfa_serial_adder: directed vectors on WIDTH=8/DIGIT=2
// plus randomized regression on four other geometries.
module tb_rcpfa_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  function automatic void model(input int w, input longint a, input longint b,
                                input bit ci, input bit sb, output longint s,
                                output bit co, output bit of);
    longint m, h, sa, sbv, r, sr;
    m   = longint'(1) << w;
    h   = m >> 1;
    sa  = (a >= h) ? a - m : a;
    sbv = (b >= h) ? b - m : b;
    if (!sb) begin
      r  = a + b + longint'(ci);
      sr = sa + sbv + longint'(ci);
      co = (r >= m);
    end else begin
      r  = a - b - longint'(ci);
      sr = sa - sbv - longint'(ci);
      co = (r >= 0);
    end
    s  = ((r % m) + m) % m;
    of = (sr < -h) || (sr > h - 1);
  endfunction

  logic       d_iv = 1'b0, d_or = 1'b0;
  logic       d_ir, d_ov, d_co, d_of;
  logic       d_ci = 1'b0, d_sb = 1'b0;
  logic [7:0] d_a = '0, d_b = '0, d_s;

  rcpfa_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_iv), .in_ready(d_ir),
    .A(d_a), .B(d_b), .Cin(d_ci), .Sub(d_sb),
    .out_valid(d_ov), .out_ready(d_or),
    .Sum(d_s), .Cout(d_co), .Ovf(d_of)
  );

  generate
    for (genvar g = 0; g < 4; g++) begin : g_cfg
      localparam int W = (g == 2) ? 16 : (g == 3) ? 32 : 8;
      localparam int D = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 4 : 2;
      localparam int N = W / D;
      logic         iv = 1'b0, ordy = 1'b0;
      logic         ir, ov, co, of;
      logic         ci = 1'b0, sb = 1'b0;
      logic [W-1:0] a = '0, b = '0, s;

      rcpfa_serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ir),
        .A(a), .B(b), .Cin(ci), .Sub(sb),
        .out_valid(ov), .out_ready(ordy),
        .Sum(s), .Cout(co), .Ovf(of)
      );

      task automatic run(input int nops);
        longint es;
        bit eco, eof;
        int lat;
        logic [W-1:0] ta, tb;
        logic tci, tsb;
        for (int k = 0; k < nops; k++) begin
          ta  = (k % 7 == 0) ? '1 : W'($urandom);
          tb  = (k % 5 == 0) ? '1 : W'($urandom);
          tci = 1'($urandom_range(0, 1));
          tsb = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 2)) @(negedge clk);
          @(negedge clk);
          a = ta; b = tb; ci = tci; sb = tsb; iv = 1'b1;
          @(posedge clk);
          @(negedge clk);
          iv = 1'b0; a = W'($urandom); b = W'($urandom); sb = ~tsb;
          lat = 0;
          while (!ov && lat < N + 10) begin
            @(posedge clk); lat++; @(negedge clk);
          end
          model(W, longint'(ta), longint'(tb), tci, tsb, es, eco, eof);
          total++;
          if (lat != N || s !== W'(es) || co !== eco || of !== eof) begin
            bad++;
            $display("FAIL rand W=%0d D=%0d lat=%0d/%0d sum=%h/%h co=%b/%b ovf=%b/%b",
                     W, D, lat, N, s, W'(es), co, eco, of, eof);
          end
          repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            total++;
            if (ov !== 1'b1 || ir !== 1'b0) begin
              bad++;
              $display("FAIL rand_stall W=%0d D=%0d ov=%b ir=%b need 1 0", W, D, ov, ir);
            end
          end
          ordy = 1'b1;
          @(posedge clk);
          @(negedge clk);
          ordy = 1'b0;
          total++;
          if (ov !== 1'b0 || ir !== 1'b1) begin
            bad++;
            $display("FAIL rand_pop W=%0d D=%0d ov=%b ir=%b need 0 1", W, D, ov, ir);
          end
        end
      endtask
    end
  endgenerate

  task automatic d_start(input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb);
    @(negedge clk);
    d_a = a; d_b = b; d_ci = ci; d_sb = sb; d_iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_iv = 1'b0;
  endtask

  task automatic d_wait(output int lat);
    lat = 0;
    while (!d_ov && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  task automatic d_pop();
    d_or = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_or = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({d_ir, d_ov} !== 2'b10) begin
      bad++;
      $display("FAIL reset_hs ir,ov=%b need 10", {d_ir, d_ov});
    end
    total++;
    if ({d_s, d_co, d_of} !== 10'h0) begin
      bad++;
      $display("FAIL reset_out sum=%h co=%b ovf=%b need 0", d_s, d_co, d_of);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [7:0] va[6] = '{8'h5A, 8'hFF, 8'h7F, 8'h10, 8'h00, 8'h80};
    logic [7:0] vb[6] = '{8'h3C, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01};
    logic       vc[6] = '{0, 0, 1, 0, 0, 0};
    logic       vs[6] = '{0, 0, 0, 1, 1, 1};
    logic [7:0] es[6] = '{8'h96, 8'h00, 8'h80, 8'h0F, 8'hFF, 8'h7F};
    logic       ec[6] = '{0, 1, 0, 1, 0, 1};
    logic       eo[6] = '{1, 0, 1, 0, 0, 1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      d_start(va[i], vb[i], vc[i], vs[i]);
      d_wait(lat);
      total++;
      if (lat != 4) begin
        bad++;
        $display("FAIL vec%0d_latency got=%0d need=4", i, lat);
      end
      total++;
      if (d_s !== es[i]) begin
        bad++;
        $display("FAIL vec%0d_sum got=%h need=%h", i, d_s, es[i]);
      end
      total++;
      if (d_co !== ec[i] || d_of !== eo[i]) begin
        bad++;
        $display("FAIL vec%0d_flags co=%b ovf=%b need %b %b", i, d_co, d_of, ec[i], eo[i]);
      end
      d_pop();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    d_start(8'h5A, 8'h3C, 1'b0, 1'b0);
    lat = 0;
    while (!d_ov && lat < 20) begin
      d_a = 8'($urandom); d_b = 8'($urandom);
      d_ci = 1'($urandom); d_sb = 1'($urandom);
      @(posedge clk); lat++; @(negedge clk);
    end
    total++;
    if (lat != 4 || {d_s, d_co, d_of} !== {8'h96, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL bp_result lat=%0d sum=%h co=%b ovf=%b need 4 96 0 1", lat, d_s, d_co, d_of);
    end
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({d_ov, d_ir, d_s, d_co, d_of} !== {1'b1, 1'b0, 8'h96, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL bp_hold ov=%b ir=%b sum=%h co=%b ovf=%b need 1 0 96 0 1",
                 d_ov, d_ir, d_s, d_co, d_of);
      end
    end
    d_pop();
    total++;
    if (d_ir !== 1'b1 || d_ov !== 1'b0) begin
      bad++;
      $display("FAIL bp_release ir=%b ov=%b need 1 0", d_ir, d_ov);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen;
    d_start(8'h33, 8'h44, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({d_ir, d_ov, d_s, d_co, d_of} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL abort_reset ir=%b ov=%b sum=%h co=%b ovf=%b need 1 0 00 0 0",
               d_ir, d_ov, d_s, d_co, d_of);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (d_ov) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_no_valid out_valid seen=1 need 0");
    end
    d_start(8'h01, 8'h01, 1'b0, 1'b0);
    d_wait(lat);
    total++;
    if (lat != 4 || d_s !== 8'h02) begin
      bad++;
      $display("FAIL abort_next lat=%0d sum=%h need 4 02", lat, d_s);
    end
    d_pop();
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int lat;
    @(negedge clk);
    d_a = 8'h12; d_b = 8'h34; d_ci = 1'b0; d_sb = 1'b0;
    d_iv = 1'b1; d_or = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (d_ir) acc.push_back(c);
      @(negedge clk);
    end
    d_iv = 1'b0;
    total++;
    if (acc.size() < 4) begin
      bad++;
      $display("FAIL b2b_count accepts=%0d need>=4", acc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        total++;
        if (acc[i] - acc[i-1] != 6) begin
          bad++;
          $display("FAIL b2b_gap%0d got=%0d need=6", i, acc[i] - acc[i-1]);
        end
      end
    end
    d_wait(lat);
    total++;
    if (d_ov !== 1'b1 || d_s !== 8'h46) begin
      bad++;
      $display("FAIL b2b_sum ov=%b sum=%h need 1 46", d_ov, d_s);
    end
    @(posedge clk);
    @(negedge clk);
    d_or = 1'b0;
  endtask

  task automatic test_random();
    g_cfg[0].run(40);
    g_cfg[1].run(40);
    g_cfg[2].run(40);
    g_cfg[3].run(40);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
